// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared types and helpers for the nibble-serial adder.
// Revision : 1.0  initial release
// ============================================================================
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_if
// Purpose  : Operand/result valid-ready bundle for the nibble-serial adder.
// Revision : 1.0  initial release
// ============================================================================
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_csa4_slice.sv
`default_nettype none
// ============================================================================
// Module   : csa4_slice
// Purpose  : Combinational 4-bit carry-select adder slice.
// Revision : 1.0  initial release
// ============================================================================
module csa4_slice
    import adder_pkg::*;
(
    input  wire logic [NIBBLE_W-1:0] a,
    input  wire logic [NIBBLE_W-1:0] b,
    input  wire logic                cin,
    output logic      [NIBBLE_W-1:0] s,
    output logic                     cout
);

    logic [NIBBLE_W-1:0] w_s0;
    logic [NIBBLE_W-1:0] w_s1;
    logic                w_c0;
    logic                w_c1;

    // Both ripple chains run in parallel; cin only picks one at the end.
    always_comb begin
        w_s0 = '0;
        w_s1 = '0;
        w_c0 = 1'b0;
        w_c1 = 1'b1;
        for (int i = 0; i < NIBBLE_W; i++) begin
            w_s0[i] = a[i] ^ b[i] ^ w_c0;
            w_c0    = (a[i] & b[i]) | (w_c0 & (a[i] ^ b[i]));
            w_s1[i] = a[i] ^ b[i] ^ w_c1;
            w_c1    = (a[i] & b[i]) | (w_c1 & (a[i] ^ b[i]));
        end
    end

    assign s    = cin ? w_s1 : w_s0;
    assign cout = cin ? w_c1 : w_c0;

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder
// Purpose  : WIDTH-bit adder processing one nibble per cycle, valid/ready I/O.
// Revision : 1.0  initial release
// ============================================================================
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    nibble_serial_adder_if.slave bus
);

    localparam int NIB = nib_count(WIDTH);
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NIB - 1);

    generate
        if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t              r_state;
    state_t              w_next;
    logic [WIDTH-1:0]    r_a_sh;
    logic [WIDTH-1:0]    r_b_sh;
    logic [WIDTH-1:0]    r_sum_sh;
    logic [WIDTH-1:0]    w_sum_next;
    logic                r_carry;
    logic [CW-1:0]       r_cnt;
    logic                r_a_msb;
    logic                r_b_msb;
    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_busy;
    logic                w_accept;
    logic [NIBBLE_W-1:0] w_slice_s;
    logic                w_slice_c;

    csa4_slice u_slice (
        .a    (r_a_sh[NIBBLE_W-1:0]),
        .b    (r_b_sh[NIBBLE_W-1:0]),
        .cin  (r_carry),
        .s    (w_slice_s),
        .cout (w_slice_c)
    );

    // Each new nibble enters at the top, so after NIB shifts nibble 0 sits at the bottom.
    generate
        if (NIB == 1) begin : g_single
            assign w_sum_next = w_slice_s;
        end else begin : g_multi
            assign w_sum_next = {w_slice_s, r_sum_sh[WIDTH-1:NIBBLE_W]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = rst_n;
                if (bus.in_valid && rst_n) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (r_cnt == C_LAST) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                w_in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    w_next = bus.in_valid ? RUN : IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_accept = bus.in_valid & w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
        end else if (r_state == RUN) begin
            r_a_sh   <= r_a_sh >> NIBBLE_W;
            r_b_sh   <= r_b_sh >> NIBBLE_W;
            r_sum_sh <= w_sum_next;
            r_carry  <= w_slice_c;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_sum_sh;
    assign bus.cout      = w_out_valid & r_carry;
    assign bus.ovf       = w_out_valid & (r_a_msb == r_b_msb) & (r_sum_sh[WIDTH-1] != r_a_msb);

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Purpose  : Directed and randomized self-checking bench for nibble_serial_adder.
// Revision : 1.0  initial release
// ============================================================================
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from integer arithmetic on the operands.
    function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv, input logic ci);
        logic [16:0] u;
        int          s;
        logic        o;
        u = {1'b0, av} + {1'b0, bv} + {16'd0, ci};
        s = int'($signed(av)) + int'($signed(bv)) + int'(ci);
        o = (s > 32767) || (s < -32768);
        return {o, u};
    endfunction

    function automatic logic [17:0] observed();
        return {bus.ovf, bus.cout, bus.sum};
    endfunction

    // Called at a negedge where the DUT can accept; returns at the next negedge.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic ci);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = ci;
        #1;
        check("in_ready_accept", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.cin      = 1'($urandom);
    endtask

    // Entered at the first negedge after accept; returns at the last DONE negedge.
    task automatic expect_result(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                                 input int hold, input string tag);
        logic [17:0] exp;
        exp = model(av, bv, ci);
        for (int k = 1; k < NIB + 1; k++) begin
            check({tag, "_run_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, "_run_valid"}, 32'(bus.out_valid), 32'd0);
            check({tag, "_run_busy"}, 32'(bus.busy), 32'd1);
            @(negedge clk);
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_result"}, 32'(observed()), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_result"}, 32'(observed()), 32'(exp));
            check({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
        end
    endtask

    task automatic random_sweep(input int total);
        logic [17:0] exp_q[$];
        logic [17:0] exp;
        logic [15:0] av;
        logic [15:0] bv;
        logic        ci;
        int          accepted;
        int          cycles;
        accepted = 0;
        cycles   = 0;
        while ((accepted < total || exp_q.size() != 0) && cycles < 40000) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            ci = 1'($urandom);
            bus.in_valid  = (accepted < total) ? 1'($urandom) : 1'b0;
            bus.a         = av;
            bus.b         = bv;
            bus.cin       = ci;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sweep_unexpected_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("sweep_result", 32'(observed()), 32'(exp));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(av, bv, ci));
                accepted++;
            end
            @(negedge clk);
            cycles++;
        end
        bus.in_valid = 1'b0;
        check("sweep_accepted", 32'(accepted), 32'(total));
        check("sweep_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_outputs", 32'(observed()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(bus.in_ready), 32'd1);

        // Basic latency with out_ready held high
        bus.out_ready = 1'b1;
        issue(16'h1234, 16'h4321, 1'b1);
        expect_result(16'h1234, 16'h4321, 1'b1, 0, "basic");
        check("basic_sum", 32'(bus.sum), 32'h5556);
        @(negedge clk);
        check("basic_idle_valid", 32'(bus.out_valid), 32'd0);
        check("basic_idle_busy", 32'(bus.busy), 32'd0);

        // Carry ripple and signed overflow
        issue(16'hFFFF, 16'h0001, 1'b0);
        expect_result(16'hFFFF, 16'h0001, 1'b0, 0, "wrap");
        check("wrap_cout_sum", 32'({bus.cout, bus.sum}), 32'h10000);
        @(negedge clk);
        issue(16'h7FFF, 16'h0001, 1'b0);
        expect_result(16'h7FFF, 16'h0001, 1'b0, 0, "ovf_pos");
        check("ovf_pos_flag", 32'({bus.ovf, bus.sum}), 32'h18000);
        @(negedge clk);

        // Back-pressure: result held for four DONE cycles
        bus.out_ready = 1'b0;
        issue(16'h8000, 16'h8000, 1'b0);
        expect_result(16'h8000, 16'h8000, 1'b0, 3, "hold");
        check("hold_flags", 32'({bus.ovf, bus.cout, bus.sum}), 32'h30000);
        bus.out_ready = 1'b1;
        #1;
        check("hold_release_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check("hold_release_valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back: second pair accepted in DONE
        issue(16'h1111, 16'h2222, 1'b0);
        expect_result(16'h1111, 16'h2222, 1'b0, 0, "b2b_first");
        issue(16'h00FF, 16'h0F01, 1'b0);
        expect_result(16'h00FF, 16'h0F01, 1'b0, 0, "b2b_second");
        check("b2b_sum", 32'(bus.sum), 32'h1000);
        @(negedge clk);

        // Asynchronous reset while counter == 2
        issue(16'h5555, 16'h1111, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_sum", 32'(bus.sum), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle_valid", 32'(bus.out_valid), 32'd0);
        issue(16'h0003, 16'h0004, 1'b0);
        expect_result(16'h0003, 16'h0004, 1'b0, 0, "post_rst");
        check("post_rst_sum", 32'(bus.sum), 32'h0007);
        @(negedge clk);

        random_sweep(1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
